// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rob_pkg
// Purpose : Shared types and pointer helpers for the multi-port reorder buffer
// Revision: 1.0 - initial release
// ============================================================================
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package rob_pkg;
    localparam int c_REG_BITS  = 5;
    localparam int c_WORD_SIZE = `WORD_SIZE;

    typedef struct packed {
        logic                   valid;
        logic                   ready;
        logic                   exception;
        logic [c_REG_BITS-1:0]  rd;
        logic [c_WORD_SIZE-1:0] value;
    } rob_entry_t;

    // amount never exceeds depth, so a single subtract wraps correctly
    function automatic int wrap_inc(input int ptr, input int amount, input int depth);
        int s;
        s = ptr + amount;
        if (s >= depth) s = s - depth;
        return s;
    endfunction

    function automatic int rob_age(input int idx, input int head, input int depth);
        return (idx >= head) ? (idx - head) : (idx + depth - head);
    endfunction

    function automatic logic is_younger(input int a, input int b, input int head, input int depth);
        return rob_age(a, head, depth) > rob_age(b, head, depth);
    endfunction
endpackage

`default_nettype wire

// File: rtl/rob_commit_select.sv
`default_nettype none
// ============================================================================
// Module  : rob_commit_select
// Purpose : In-order retire scan over the oldest COMMIT_WIDTH entries
// Revision: 1.0 - initial release
// ============================================================================
module rob_commit_select #(
    parameter int COMMIT_WIDTH = 2,
    parameter int N_BITS       = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic [COMMIT_WIDTH-1:0] i_scan_valid,
    input  logic [COMMIT_WIDTH-1:0] i_scan_ready,
    input  logic [COMMIT_WIDTH-1:0] i_scan_exc,
    output logic [COMMIT_WIDTH-1:0] o_retire,
    output logic [N_BITS-1:0]       o_n_retire,
    output logic                    o_exc_head
);
    logic w_stop;

    always_comb begin
        o_retire   = '0;
        o_n_retire = '0;
        w_stop     = 1'b0;
        o_exc_head = i_scan_valid[0] && i_scan_ready[0] && i_scan_exc[0];
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (!w_stop && i_scan_valid[k] && i_scan_ready[k] && !i_scan_exc[k]) begin
                o_retire[k] = 1'b1;
                o_n_retire  = o_n_retire + N_BITS'(1);
            end else begin
                w_stop = 1'b1;
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/rob_multi.sv
`default_nettype none
// ============================================================================
// Module  : rob_multi
// Purpose : Circular reorder buffer, multi-port writeback, wide in-order commit
// Revision: 1.0 - initial release
// ============================================================================
module rob_multi
    import rob_pkg::*;
#(
    parameter int WORD_SIZE    = `WORD_SIZE,
    parameter int ROB_ENTRIES  = 10,
    parameter int WB_PORTS     = 2,
    parameter int COMMIT_WIDTH = 2,
    parameter int REG_BITS     = c_REG_BITS,
    parameter int TAG_BITS     = $clog2(ROB_ENTRIES)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             alloc_valid,
    input  logic [REG_BITS-1:0]              alloc_rd,
    output logic [TAG_BITS-1:0]              alloc_tag,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(ROB_ENTRIES+1)-1:0] count,
    input  logic [WB_PORTS-1:0]              wb_valid,
    input  logic [WB_PORTS*TAG_BITS-1:0]     wb_tag,
    input  logic [WB_PORTS*WORD_SIZE-1:0]    wb_value,
    input  logic [WB_PORTS-1:0]              wb_exception,
    input  logic                             flush_valid,
    input  logic [TAG_BITS-1:0]              flush_tag,
    output logic [COMMIT_WIDTH-1:0]          commit_valid,
    output logic [COMMIT_WIDTH*TAG_BITS-1:0] commit_tag,
    output logic [COMMIT_WIDTH*REG_BITS-1:0] commit_rd,
    output logic [COMMIT_WIDTH*WORD_SIZE-1:0] commit_value,
    output logic                             exc_valid,
    output logic [TAG_BITS-1:0]              exc_tag
);
    localparam int c_CNT_BITS = $clog2(ROB_ENTRIES + 1);
    localparam int c_N_BITS   = $clog2(COMMIT_WIDTH + 1);

    rob_entry_t                       r_ent [ROB_ENTRIES];
    logic [TAG_BITS-1:0]              r_head;
    logic [TAG_BITS-1:0]              r_tail;
    logic [c_CNT_BITS-1:0]            r_count;
    logic [COMMIT_WIDTH-1:0]          r_commit_valid;
    logic [COMMIT_WIDTH*TAG_BITS-1:0] r_commit_tag;
    logic [COMMIT_WIDTH*REG_BITS-1:0] r_commit_rd;
    logic [COMMIT_WIDTH*WORD_SIZE-1:0] r_commit_value;
    logic                             r_exc_valid;
    logic [TAG_BITS-1:0]              r_exc_tag;

    logic                    w_flush_ok;
    int                      w_ft_age;
    int                      w_squash_cnt;
    logic [ROB_ENTRIES-1:0]  w_squash;
    logic [ROB_ENTRIES-1:0]  w_wb_hit;
    logic [WORD_SIZE-1:0]    w_wb_val [ROB_ENTRIES];
    logic [ROB_ENTRIES-1:0]  w_wb_exc;
    int                      w_scan_idx [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0] w_scan_valid;
    logic [COMMIT_WIDTH-1:0] w_scan_ready;
    logic [COMMIT_WIDTH-1:0] w_scan_exc;
    logic [COMMIT_WIDTH-1:0] w_retire;
    logic [c_N_BITS-1:0]     w_n_retire;
    logic                    w_exc_head;
    logic [ROB_ENTRIES-1:0]  w_retire_ent;
    logic                    w_alloc_ok;

    assign alloc_tag    = r_tail;
    assign count        = r_count;
    assign full         = (int'(r_count) == ROB_ENTRIES);
    assign empty        = (r_count == '0);
    assign commit_valid = r_commit_valid;
    assign commit_tag   = r_commit_tag;
    assign commit_rd    = r_commit_rd;
    assign commit_value = r_commit_value;
    assign exc_valid    = r_exc_valid;
    assign exc_tag      = r_exc_tag;

    // Flush, squash mask and per-entry writeback merge; lookups loop over real
    // entries so out-of-range tags simply never match.
    always_comb begin
        w_flush_ok = 1'b0;
        for (int i = 0; i < ROB_ENTRIES; i++) begin
            if (flush_tag == TAG_BITS'(i) && r_ent[i].valid) w_flush_ok = flush_valid;
        end
        w_ft_age     = rob_age(int'(flush_tag), int'(r_head), ROB_ENTRIES);
        w_squash_cnt = w_flush_ok ? (int'(r_count) - w_ft_age - 1) : 0;
        for (int i = 0; i < ROB_ENTRIES; i++) begin
            w_squash[i] = w_flush_ok && r_ent[i].valid &&
                          is_younger(i, int'(flush_tag), int'(r_head), ROB_ENTRIES);
            w_wb_hit[i] = 1'b0;
            w_wb_val[i] = '0;
            w_wb_exc[i] = 1'b0;
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p] && wb_tag[p*TAG_BITS +: TAG_BITS] == TAG_BITS'(i) &&
                    r_ent[i].valid && !w_squash[i]) begin
                    w_wb_hit[i] = 1'b1;
                    w_wb_val[i] = wb_value[p*WORD_SIZE +: WORD_SIZE];
                    w_wb_exc[i] = wb_exception[p];
                end
            end
        end
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            w_scan_idx[k]   = wrap_inc(int'(r_head), k, ROB_ENTRIES);
            w_scan_valid[k] = r_ent[w_scan_idx[k]].valid && !w_squash[w_scan_idx[k]];
            w_scan_ready[k] = r_ent[w_scan_idx[k]].ready;
            w_scan_exc[k]   = r_ent[w_scan_idx[k]].exception;
        end
    end

    rob_commit_select #(
        .COMMIT_WIDTH (COMMIT_WIDTH),
        .N_BITS       (c_N_BITS)
    ) u_commit_select (
        .i_scan_valid (w_scan_valid),
        .i_scan_ready (w_scan_ready),
        .i_scan_exc   (w_scan_exc),
        .o_retire     (w_retire),
        .o_n_retire   (w_n_retire),
        .o_exc_head   (w_exc_head)
    );

    always_comb begin
        w_retire_ent = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (w_retire[k]) w_retire_ent[w_scan_idx[k]] = 1'b1;
        end
        w_alloc_ok = alloc_valid && !full && !w_flush_ok;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ROB_ENTRIES; i++) r_ent[i] <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= '0;
            r_commit_tag   <= '0;
            r_commit_rd    <= '0;
            r_commit_value <= '0;
            r_exc_valid    <= 1'b0;
            r_exc_tag      <= '0;
        end else if (w_exc_head) begin
            // Precise exception: everything in flight is discarded
            for (int i = 0; i < ROB_ENTRIES; i++) r_ent[i] <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= '0;
            r_commit_tag   <= '0;
            r_commit_rd    <= '0;
            r_commit_value <= '0;
            r_exc_valid    <= 1'b1;
            r_exc_tag      <= r_head;
        end else begin
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                if (w_alloc_ok && r_tail == TAG_BITS'(i)) begin
                    r_ent[i].valid     <= 1'b1;
                    r_ent[i].ready     <= 1'b0;
                    r_ent[i].exception <= 1'b0;
                    r_ent[i].rd        <= alloc_rd;
                    r_ent[i].value     <= '0;
                end else if (w_retire_ent[i] || w_squash[i]) begin
                    r_ent[i] <= '0;
                end else if (w_wb_hit[i]) begin
                    r_ent[i].ready     <= 1'b1;
                    r_ent[i].value     <= w_wb_val[i];
                    r_ent[i].exception <= w_wb_exc[i];
                end
            end
            r_head <= TAG_BITS'(wrap_inc(int'(r_head), int'(w_n_retire), ROB_ENTRIES));
            if (w_flush_ok)
                r_tail <= TAG_BITS'(wrap_inc(int'(flush_tag), 1, ROB_ENTRIES));
            else if (w_alloc_ok)
                r_tail <= TAG_BITS'(wrap_inc(int'(r_tail), 1, ROB_ENTRIES));
            r_count <= c_CNT_BITS'(int'(r_count) + (w_alloc_ok ? 1 : 0)
                                   - int'(w_n_retire) - w_squash_cnt);
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                r_commit_valid[k] <= w_retire[k];
                r_commit_tag[k*TAG_BITS +: TAG_BITS] <=
                    w_retire[k] ? TAG_BITS'(w_scan_idx[k]) : '0;
                r_commit_rd[k*REG_BITS +: REG_BITS] <=
                    w_retire[k] ? r_ent[w_scan_idx[k]].rd : '0;
                r_commit_value[k*WORD_SIZE +: WORD_SIZE] <=
                    w_retire[k] ? r_ent[w_scan_idx[k]].value : '0;
            end
            r_exc_valid <= 1'b0;
            r_exc_tag   <= '0;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_rob_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_rob_multi
// Purpose : Scoreboard bench for rob_multi (10 entries, 2 wb ports, 2 commit)
// Revision: 1.0 - initial release
// ============================================================================
module tb_rob_multi;
    localparam int c_D  = 10;
    localparam int c_TB = 4;
    localparam int c_RB = 5;
    localparam int c_WS = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             alloc_valid;
    logic [c_RB-1:0]  alloc_rd;
    logic [c_TB-1:0]  alloc_tag;
    logic             full, empty;
    logic [3:0]       count;
    logic [1:0]       wb_valid;
    logic [2*c_TB-1:0] wb_tag;
    logic [2*c_WS-1:0] wb_value;
    logic [1:0]       wb_exception;
    logic             flush_valid;
    logic [c_TB-1:0]  flush_tag;
    logic [1:0]       commit_valid;
    logic [2*c_TB-1:0] commit_tag;
    logic [2*c_RB-1:0] commit_rd;
    logic [2*c_WS-1:0] commit_value;
    logic             exc_valid;
    logic [c_TB-1:0]  exc_tag;

    typedef struct {
        logic [c_TB-1:0] tag;
        logic [c_RB-1:0] rd;
    } exp_t;

    exp_t             sbq[$];
    logic [c_WS-1:0]  mval [16];
    int               n_tests = 0;
    int               n_fail  = 0;

    rob_multi #(
        .WORD_SIZE(c_WS), .ROB_ENTRIES(c_D), .WB_PORTS(2), .COMMIT_WIDTH(2), .REG_BITS(c_RB)
    ) dut (
        .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .alloc_tag(alloc_tag), .full(full), .empty(empty), .count(count),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .wb_exception(wb_exception), .flush_valid(flush_valid), .flush_tag(flush_tag),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
        .commit_value(commit_value), .exc_valid(exc_valid), .exc_tag(exc_tag)
    );

    always #5 clk = ~clk;

    // Advance one edge, then pop and compare every retired slot against the scoreboard
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (commit_valid[k]) begin
                n_tests++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL commit_unexpected slot%0d: got tag %0d, expected no commit",
                             k, commit_tag[k*c_TB +: c_TB]);
                end else begin
                    e = sbq.pop_front();
                    if (commit_tag[k*c_TB +: c_TB] !== e.tag || commit_rd[k*c_RB +: c_RB] !== e.rd ||
                        commit_value[k*c_WS +: c_WS] !== mval[e.tag]) begin
                        n_fail++;
                        $display("FAIL commit_slot%0d: got tag %0d rd %0d val %0h, expected tag %0d rd %0d val %0h",
                                 k, commit_tag[k*c_TB +: c_TB], commit_rd[k*c_RB +: c_RB],
                                 commit_value[k*c_WS +: c_WS], e.tag, e.rd, mval[e.tag]);
                    end
                end
            end
        end
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0; alloc_rd = '0; wb_valid = '0; wb_tag = '0; wb_value = '0;
        wb_exception = '0; flush_valid = 1'b0; flush_tag = '0;
    endtask

    task automatic set_wb(input int p, input int tag, input logic [c_WS-1:0] val, input logic exc);
        wb_valid[p] = 1'b1;
        wb_tag[p*c_TB +: c_TB] = c_TB'(tag);
        wb_value[p*c_WS +: c_WS] = val;
        wb_exception[p] = exc;
        if (!exc) mval[tag] = val;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sbq.delete();
        tick();
        rst = 1'b1;
    endtask

    task automatic alloc_n(input int n, input int first_tag);
        for (int i = 0; i < n; i++) begin
            alloc_valid = 1'b1;
            alloc_rd = c_RB'(i + 3);
            n_tests++;
            if (alloc_tag !== c_TB'(first_tag + i)) begin
                n_fail++;
                $display("FAIL alloc_tag: got %0d, expected %0d", alloc_tag, first_tag + i);
            end
            sbq.push_back('{c_TB'(first_tag + i), c_RB'(i + 3)});
            tick();
        end
        alloc_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        tick(); tick();
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b, expected 1", empty); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b, expected 0", full); end
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d, expected 0", count); end
        n_tests++; if (commit_valid !== 2'b00) begin n_fail++; $display("FAIL reset_commit_valid: got %b, expected 00", commit_valid); end
        n_tests++; if (exc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_exc_valid: got %b, expected 0", exc_valid); end
        n_tests++; if (alloc_tag !== 4'd0) begin n_fail++; $display("FAIL reset_alloc_tag: got %0d, expected 0", alloc_tag); end
        rst = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 11; i++) begin
            alloc_valid = 1'b1;
            alloc_rd = c_RB'(i + 1);
            n_tests++;
            if (alloc_tag !== c_TB'((i < 10) ? i : 0)) begin
                n_fail++;
                $display("FAIL fill_alloc_tag[%0d]: got %0d, expected %0d", i, alloc_tag, (i < 10) ? i : 0);
            end
            if (i < 10) sbq.push_back('{c_TB'(i), c_RB'(i + 1)});
            tick();
            if (i == 9) begin
                n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b, expected 1", full); end
                n_tests++; if (count !== 4'd10) begin n_fail++; $display("FAIL fill_count: got %0d, expected 10", count); end
            end
        end
        alloc_valid = 1'b0;
        n_tests++; if (count !== 4'd10) begin n_fail++; $display("FAIL fill_overflow_count: got %0d, expected 10", count); end
        n_tests++; if (alloc_tag !== 4'd0) begin n_fail++; $display("FAIL fill_overflow_tail: got %0d, expected 0", alloc_tag); end
    endtask

    task automatic test_out_of_order();
        set_wb(0, 1, 32'hAA, 1'b0);
        tick();
        idle_inputs();
        set_wb(0, 0, 32'h55, 1'b0);
        n_tests++; if (commit_valid !== 2'b00) begin n_fail++; $display("FAIL ooo_early1: got %b, expected 00", commit_valid); end
        tick();
        idle_inputs();
        n_tests++; if (commit_valid !== 2'b00) begin n_fail++; $display("FAIL ooo_early2: got %b, expected 00", commit_valid); end
        tick();
        n_tests++; if (commit_valid !== 2'b11) begin n_fail++; $display("FAIL ooo_commit: got %b, expected 11", commit_valid); end
        n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL ooo_count: got %0d, expected 8", count); end
        tick();
        n_tests++; if (commit_valid !== 2'b00) begin n_fail++; $display("FAIL ooo_after: got %b, expected 00", commit_valid); end
    endtask

    task automatic test_wrap();
        set_wb(0, 2, 32'h102, 1'b0); set_wb(1, 3, 32'h103, 1'b0);
        tick(); idle_inputs();
        set_wb(0, 4, 32'h104, 1'b0); set_wb(1, 5, 32'h105, 1'b0);
        tick(); idle_inputs();
        tick();
        alloc_n(4, 0);
        for (int t = 6; t < 14; t += 2) begin
            set_wb(0, t % c_D, 32'h200 + 32'(t), 1'b0);
            set_wb(1, (t + 1) % c_D, 32'h201 + 32'(t), 1'b0);
            tick(); idle_inputs();
        end
        tick(); tick(); tick();
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b, expected 1", empty); end
        n_tests++; if (sbq.size() != 0) begin n_fail++; $display("FAIL wrap_drain: got %0d pending, expected 0", sbq.size()); end
    endtask

    task automatic test_flush();
        do_reset();
        alloc_n(6, 0);
        flush_valid = 1'b1; flush_tag = 4'd2;
        alloc_valid = 1'b1; alloc_rd = 5'd31;
        set_wb(0, 4, 32'hDEAD, 1'b0);
        while (sbq.size() > 0 && sbq[$].tag != 4'd2) void'(sbq.pop_back());
        tick(); idle_inputs();
        n_tests++; if (count !== 4'd3) begin n_fail++; $display("FAIL flush_count: got %0d, expected 3", count); end
        n_tests++; if (alloc_tag !== 4'd3) begin n_fail++; $display("FAIL flush_tail: got %0d, expected 3", alloc_tag); end
        set_wb(0, 0, 32'h300, 1'b0); set_wb(1, 1, 32'h301, 1'b0);
        tick(); idle_inputs();
        set_wb(0, 2, 32'h302, 1'b0);
        tick(); idle_inputs();
        tick(); tick();
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %b, expected 1", empty); end
        n_tests++; if (sbq.size() != 0) begin n_fail++; $display("FAIL flush_drain: got %0d pending, expected 0", sbq.size()); end
    endtask

    task automatic test_exception();
        do_reset();
        alloc_n(4, 0);
        set_wb(0, 0, 32'hBAD, 1'b1); set_wb(1, 1, 32'h401, 1'b0);
        tick(); idle_inputs();
        sbq.delete();
        tick();
        n_tests++; if (exc_valid !== 1'b1) begin n_fail++; $display("FAIL exc_valid: got %b, expected 1", exc_valid); end
        n_tests++; if (exc_tag !== 4'd0) begin n_fail++; $display("FAIL exc_tag: got %0d, expected 0", exc_tag); end
        n_tests++; if (commit_valid !== 2'b00) begin n_fail++; $display("FAIL exc_commit: got %b, expected 00", commit_valid); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL exc_empty: got %b, expected 1", empty); end
        n_tests++; if (alloc_tag !== 4'd0) begin n_fail++; $display("FAIL exc_alloc_tag: got %0d, expected 0", alloc_tag); end
        tick();
        n_tests++; if (exc_valid !== 1'b0) begin n_fail++; $display("FAIL exc_pulse: got %b, expected 0", exc_valid); end
    endtask

    task automatic test_port_priority();
        alloc_n(1, 0);
        set_wb(0, 0, 32'h11, 1'b0); set_wb(1, 0, 32'h22, 1'b0);
        tick(); idle_inputs();
        tick();
        n_tests++; if (commit_valid !== 2'b01) begin n_fail++; $display("FAIL prio_commit: got %b, expected 01", commit_valid); end
        tick();
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL prio_empty: got %b, expected 1", empty); end
        n_tests++; if (sbq.size() != 0) begin n_fail++; $display("FAIL prio_drain: got %0d pending, expected 0", sbq.size()); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mval[i] = '0;
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_fill();
        test_out_of_order();
        test_wrap();
        test_flush();
        test_exception();
        test_port_priority();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
